// File: rtl/stream_downsizer.sv
// rtl/stream_downsizer.sv - serialises wide FIFO words into narrow beats, LSB slice first
// Each word carries its own beat count; the final beat of every word is flagged with out_last.
module stream_downsizer #(
   parameter int WIDTH = 32,
   parameter int RATIO = 4,
   localparam int OUT_W = WIDTH / RATIO,
   localparam int LEN_W = (RATIO > 2) ? $clog2(RATIO) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic [LEN_W-1:0] in_len,
   input  logic             in_val,
   output logic             in_rdy,
   output logic [OUT_W-1:0] out_data,
   output logic             out_last,
   output logic             out_val,
   input  logic             out_rdy,
   output logic             busy
);

   typedef enum logic {IDLE, SEND} state_t;

   localparam logic [LEN_W:0] MAX_LEN = (LEN_W + 1)'(RATIO - 1);

   state_t           state;
   logic [WIDTH-1:0] hold_data;
   logic [LEN_W-1:0] hold_len;
   logic [LEN_W-1:0] idx;
   logic [LEN_W-1:0] len_clamped;
   logic [OUT_W-1:0] slices [RATIO];

   for (genvar k = 0; k < RATIO; k++) begin : g_slice
      assign slices[k] = hold_data[k*OUT_W +: OUT_W];
   end

   // Only reachable for non-power-of-two RATIO, where in_len can encode more beats than exist.
   always_comb begin
      len_clamped = in_len;
      if ({1'b0, in_len} > MAX_LEN)
         len_clamped = MAX_LEN[LEN_W-1:0];
   end

   assign out_data = slices[idx];
   assign out_last = out_val && (idx == hold_len);
   assign busy     = out_val;

   // Refill is allowed in the same cycle the last beat leaves, so words stream without a bubble.
   always_comb begin
      in_rdy = 1'b0;
      if (!reset)
         in_rdy = (state == IDLE) || (state == SEND && out_val && out_rdy && out_last);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         idx     <= '0;
         out_val <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_val) begin
                  hold_data <= in_data;
                  hold_len  <= len_clamped;
                  idx       <= '0;
                  out_val   <= 1'b1;
                  state     <= SEND;
               end
            end
            SEND: begin
               if (out_rdy) begin
                  if (idx != hold_len) begin
                     idx <= idx + 1'b1;
                  end else if (in_val) begin
                     hold_data <= in_data;
                     hold_len  <= len_clamped;
                     idx       <= '0;
                  end else begin
                     out_val <= 1'b0;
                     state   <= IDLE;
                  end
               end
            end
            default: begin
               state   <= IDLE;
               out_val <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/stream_downsizer.md
Name: stream_downsizer

Overview:
- Reader-side companion to the team's valid/ready FIFO. It pops wide words from a FIFO output and serialises each into WIDTH/RATIO-bit beats on a narrower valid/ready stream, least-significant slice first.
- A per-word length field allows short final words. The last beat of each word is flagged, so a downstream framer sees word boundaries.
- Sits between a FIFO data_out/data_out_val/data_out_rdy port and a narrow consumer (UART/SPI TX, narrow bus).

Parameters:
- WIDTH, 32, input word width in bits. Must be an integer multiple of RATIO.
- RATIO, 4, beats per full word. Must be ≥2.
- OUT_W, WIDTH/RATIO, output beat width. Derived; not overridable.
- LEN_W, max(1,$clog2(RATIO)), width of in_len.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  wide word; slice k = in_data[k*OUT_W +: OUT_W].
- in_len  input  LEN_W  number of valid beats minus 1 (0 → 1 beat, RATIO-1 → full word).
- in_val  input  1  in_data/in_len valid.
- in_rdy  output  1  block can accept a word this cycle.
- out_data  output  OUT_W  current beat.
- out_last  output  1  current beat is the final beat of its word.
- out_val  output  1  out_data/out_last valid.
- out_rdy  input  1  consumer accepts the beat.
- busy  output  1  a word is held (equal to out_val).

Behaviour:
- Interface clocking: clock clk; reset reset, synchronous, active-high.
- Transfers: an input transfer occurs when in_val && in_rdy at a rising clk edge. An output transfer occurs when out_val && out_rdy.
- State: holding register hold_data[WIDTH], hold_len[LEN_W], beat index idx[LEN_W], FSM {IDLE, SEND}.
- Reset: FSM=IDLE, idx=0, out_val=0, out_last=0, busy=0.
  - in_rdy=0 while reset is high; no transfer is recognised during a reset cycle.
  - hold_data is not reset; out_data is don't-care while out_val=0.
- IDLE:
  - out_val=0, in_rdy=1.
  - On an input transfer: capture in_data and in_len, idx←0, go to SEND.
- SEND:
  - out_val=1, out_data = hold_data[idx*OUT_W +: OUT_W], out_last = (idx==hold_len).
  - Output transfer with idx<hold_len: idx←idx+1; stay in SEND.
  - Output transfer with idx==hold_len (last beat): if in_val, capture the new word, idx←0, stay in SEND (back-to-back, no bubble). Otherwise go to IDLE.
- in_rdy = (state==IDLE) || (state==SEND && out_val && out_rdy && out_last) — a combinational path from out_rdy to in_rdy.
- Latency: a word accepted at edge N presents beat 0 in the cycle after edge N. A word of L+1 beats occupies L+1 output transfers.
- Stall: out_val never deasserts once asserted until out_rdy. out_data and out_last stay stable while out_val && !out_rdy.
- in_len ≥ RATIO is impossible when RATIO is a power of two. For non-power-of-two RATIO, values > RATIO-1 are clamped to RATIO-1 at capture.
- Input fields are sampled only on an input transfer. Changes to in_data or in_len while in_rdy=0 have no effect.
- Reset mid-word: the remaining beats are discarded, out_val=0 in the cycle after reset, and no partial word resumes.
- Throughput: with in_val=1 and out_rdy=1 continuously, out_val stays 1 every cycle after the first word. One input word is consumed per (in_len+1) cycles.

Test Plan:
- Single full word: WIDTH=32, RATIO=4, in_data=0xDDCCBBAA, in_len=3, out_rdy=1.
  → beats 0xAA, 0xBB, 0xCC, 0xDD on 4 consecutive cycles starting 1 cycle after accept; out_last only on 0xDD; then IDLE with in_rdy=1.
- Short word: in_data=0x44332211, in_len=1.
  → beats 0x11, then 0x22 with out_last=1; 0x33/0x44 never appear.
- Back-to-back: two words 0x03020100 and 0x07060504 (in_len=3), in_val held high, out_rdy=1.
  → 8 beats 0x00..0x07 with no gap; the second word is accepted in the same cycle as beat 0x03; out_last on 0x03 and 0x07.
- Backpressure: out_rdy toggles 1,0,0,1,… during a full word.
  → each beat is held stable while stalled, with no loss or duplication; in_rdy stays 0 until the final transfer.
- in_len=0 stream: three words with in_len=0, data low bytes 0x5A, 0xA5, 0x3C.
  → one beat per word, out_last=1 every beat, a new word accepted every cycle.
- Reset mid-word: assert reset for 1 cycle after beat 1 of 0xDDCCBBAA.
  → out_val=0 the next cycle; a fresh word 0x87654321 then emits 0x21 first.
